ghash_mul_digit: RTL and testbench
==================================

# ghash_mul_digit

Parametrised digit-serial GF(2^128) multiplier for the GCM/GHASH path of the SNOW-V AEAD datapath. It processes DIGIT bits of H per clock instead of one, and adds a built-in GHASH accumulate mode, Y ← (Y ⊕ X)·H. A valid/ready input handshake and a one-cycle output strobe let the AEAD controller stream blocks back-to-back. It sits between the keystream/ciphertext block path and the tag generator.

## Interface
- DIGIT, 1: bits of H consumed per compute cycle; legal values 1, 2, 4, 8, 16, 32. Any other value is an elaboration error.
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- H  in  128  hash subkey; sampled only on input acceptance.
- block_i  in  128  operand X; sampled only on input acceptance.
- acc  in  1  sampled on acceptance. 1: operand = block_i ⊕ block_o. 0: operand = block_i.
- clear  in  1  zeroes the accumulator. Aborts an operation in progress.
- in_valid  in  1  operand present.
- in_ready  out  1  block idle, can accept; reset 1.
- block_o  out  128  result / GHASH accumulator Y; reset 0; held until the next acceptance or clear.
- out_valid  out  1  one-cycle strobe, block_o newly valid; reset 0.

## Operation
- Bit order follows GCM: H[127] is coefficient x^0. Reduction constant R = 0xE1 followed by 120 zero bits.
- Single-bit step:
  - Z ^= V if h_bit.
  - V = (V>>1) ^ (V[0] ? R : 0).
- One compute cycle applies DIGIT chained steps. Step k within cycle c uses H_s[127 − c·DIGIT − k].
- Registers:
  - state (IDLE, COMP)
  - Z (drives block_o)
  - V
  - H_s (latched H)
  - ctr, counting 0..N−1 where N = 128/DIGIT; width $clog2(N)+1 bits
  - out_valid_reg
- IDLE:
  - in_ready=1.
  - On in_valid with clear=0 (accept): V←block_i ⊕ (acc ? Z : 0), H_s←H, Z←0, ctr←0, state←COMP.
- COMP:
  - in_ready=0.
  - Each cycle: Z,V ← DIGIT-step result; ctr←ctr+1.
  - When ctr==N−1: state←IDLE, out_valid←1 on that edge.
- clear:
  - In IDLE: Z←0 and any simultaneous in_valid is not accepted, so in_ready must be sampled with clear=0.
  - In COMP: abort; state←IDLE, Z←0, V←0, ctr←0. No out_valid for the aborted operation.
- in_valid during COMP is ignored. The source holds it until in_ready.
- The acc XOR uses the current block_o. If acceptance coincides with out_valid, the just-produced result is chained. This is correct by construction because Z already holds it.
- Reset mid-operation: all registers return to reset values immediately (asynchronous); no output strobe.

## Timing
- Acceptance at edge t0.
- COMP occupies edges t0+1 … t0+N. out_valid is high during the cycle after edge t0+N.
- Latency, acceptance to result: N+1 edges.
  - DIGIT=1: 129.
  - DIGIT=8: 17.
  - DIGIT=32: 5.
- Throughput: one block per N+1 cycles. in_ready rises in the same cycle out_valid is high, so the next block can be accepted there.
- out_valid is exactly one cycle wide. block_o is stable from that cycle until the next acceptance edge.
- Critical path: DIGIT cascaded XOR/shift stages. DIGIT=32 is the maximum supported for the target clock.

## Structure
- Shared package ghash_pkg holds:
  - GF128_R constant (0xE1 << 120)
  - state encodings CTRL_IDLE / CTRL_COMP
  - function or localparam for N from DIGIT
- Sub-module gf128_mul_step: combinational single-bit step.
  - Inputs: z, v, h_bit.
  - Outputs: z_nxt, v_nxt.
  - Instantiated DIGIT times in a generate chain inside ghash_mul_digit.

## Test plan
- H=66e94bd4ef8a2c3b884cfa59ca342b2e, block_i=0388dace60b6a392f328c2b971b2fe78, acc=0. Required: block_o=5e2ec746917062882c85b0685353deb7 at out_valid. Run for every legal DIGIT and check latency N+1.
- Follow-on with acc=1, block_i=00000000000000000000000000000080, accepted in the out_valid cycle. Required: block_o=f38cbb1ad69223dcc3457ae5b6b0f885 (GCM test case 2 tag hash).
- H=80000000000000000000000000000000 (field element 1), block_i=0123456789abcdeffedcba9876543210 → block_o equals block_i. With H=0 → block_o=0.
- Pulse clear at COMP cycle 3. Required: no out_valid, in_ready=1 the next cycle, block_o=0. A fresh operation then gives the correct result.
- Assert reset_n low mid-COMP. Required: immediately in_ready=1, out_valid=0, block_o=0.
- Hold in_valid high continuously for 10 random blocks with random acc and clear=0. Compare against a bit-serial reference model; exactly one acceptance per N+1 cycles.

Source files
------------

// File: rtl/ghash_pkg.sv
// Shared GF(2^128) types, reduction constant and controller state encoding
// for the digit-serial GHASH multiplier.
package ghash_pkg;

  typedef logic [127:0] gf128_t;

  localparam gf128_t GF128_R = {8'hE1, 120'h0};

  typedef enum logic {
    CTRL_IDLE = 1'b0,
    CTRL_COMP = 1'b1
  } ctrl_state_e;

  function automatic int digit_count(input int digit);
    return 128 / digit;
  endfunction

endpackage

// File: rtl/ghash_mul_digit_if.sv
// Operand/result handshake bundle between the AEAD controller (master)
// and the GHASH multiplier (slave).
interface ghash_mul_digit_if;
  import ghash_pkg::*;

  gf128_t H;
  gf128_t block_i;
  logic   acc;
  logic   clear;
  logic   in_valid;
  logic   in_ready;
  gf128_t block_o;
  logic   out_valid;

  modport master (
    output H, block_i, acc, clear, in_valid,
    input  in_ready, block_o, out_valid
  );

  modport slave (
    input  H, block_i, acc, clear, in_valid,
    output in_ready, block_o, out_valid
  );

endinterface

// File: rtl/gf128_mul_step.sv
// One bit of the GCM shift-and-add multiply: conditional accumulate of V
// into Z, then V times x with reduction (bit 0 is the x^127 coefficient).
module gf128_mul_step
  import ghash_pkg::*;
(
  input  gf128_t z,
  input  gf128_t v,
  input  logic   h_bit,
  output gf128_t z_nxt,
  output gf128_t v_nxt
);

  assign z_nxt = h_bit ? (z ^ v) : z;
  assign v_nxt = (v >> 1) ^ (v[0] ? GF128_R : '0);

endmodule

// File: rtl/ghash_mul_digit.sv
// Digit-serial GF(2^128) multiplier with GHASH accumulate, Y <- (Y ^ X) * H,
// consuming DIGIT bits of H per clock behind a valid/ready handshake.
module ghash_mul_digit
  import ghash_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input logic              clk,
  input logic              reset_n,
  ghash_mul_digit_if.slave bus
);

  localparam int N  = digit_count(DIGIT);
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!(DIGIT == 1 || DIGIT == 2 || DIGIT == 4 ||
        DIGIT == 8 || DIGIT == 16 || DIGIT == 32)) begin : g_bad_digit
    $error("ghash_mul_digit: DIGIT must be one of 1, 2, 4, 8, 16, 32");
  end

  ctrl_state_e   state_q, state_d;
  gf128_t        z_q, z_d;
  gf128_t        v_q, v_d;
  gf128_t        h_s_q, h_s_d;
  logic [CW-1:0] ctr_q, ctr_d;
  logic          out_valid_q, out_valid_d;
  gf128_t        z_step, v_step;

  // H_s is shifted left by DIGIT every compute cycle, so the bits for the
  // current digit always sit at the top and no variable bit-select is needed.
  for (genvar k = 0; k < DIGIT; k++) begin : g_step
    gf128_t z_in, v_in, z_out, v_out;
    if (k == 0) begin : g_head
      assign z_in = z_q;
      assign v_in = v_q;
    end else begin : g_link
      assign z_in = g_step[k-1].z_out;
      assign v_in = g_step[k-1].v_out;
    end
    gf128_mul_step u_step (
      .z     (z_in),
      .v     (v_in),
      .h_bit (h_s_q[127-k]),
      .z_nxt (z_out),
      .v_nxt (v_out)
    );
  end

  assign z_step = g_step[DIGIT-1].z_out;
  assign v_step = g_step[DIGIT-1].v_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CTRL_IDLE;
      z_q         <= '0;
      v_q         <= '0;
      h_s_q       <= '0;
      ctr_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      z_q         <= z_d;
      v_q         <= v_d;
      h_s_q       <= h_s_d;
      ctr_q       <= ctr_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    z_d         = z_q;
    v_d         = v_q;
    h_s_d       = h_s_q;
    ctr_d       = ctr_q;
    out_valid_d = 1'b0;
    case (state_q)
      CTRL_IDLE: begin
        if (bus.clear) begin
          z_d = '0;
        end else if (bus.in_valid) begin
          // z_q still holds the last result, so chaining on the strobe cycle works.
          v_d     = bus.block_i ^ (bus.acc ? z_q : '0);
          h_s_d   = bus.H;
          z_d     = '0;
          ctr_d   = '0;
          state_d = CTRL_COMP;
        end
      end
      CTRL_COMP: begin
        if (bus.clear) begin
          state_d = CTRL_IDLE;
          z_d     = '0;
          v_d     = '0;
          ctr_d   = '0;
        end else begin
          z_d   = z_step;
          v_d   = v_step;
          h_s_d = h_s_q << DIGIT;
          ctr_d = ctr_q + CW'(1);
          if (ctr_q == LAST) begin
            state_d     = CTRL_IDLE;
            out_valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = CTRL_IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == CTRL_IDLE);
  assign bus.block_o   = z_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_ghash_mul_digit.sv
// Directed bench for ghash_mul_digit: one instance per legal DIGIT for the
// GCM vector and latency, then a DIGIT=8 instance for the remaining steps.
module tb_ghash_mul_digit;
  import ghash_pkg::*;

  localparam int NDUT = 6;
  localparam int M    = 3;
  localparam int N_M  = 16;

  localparam gf128_t H1  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam gf128_t X1  = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam gf128_t Y1  = 128'h5e2ec746917062882c85b0685353deb7;
  localparam gf128_t LEN = 128'h00000000000000000000000000000080;
  localparam gf128_t Y2  = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
  localparam gf128_t ONE = 128'h80000000000000000000000000000000;
  localparam gf128_t XI  = 128'h0123456789abcdeffedcba9876543210;

  logic   clk = 1'b0;
  logic   reset_n;
  gf128_t tb_h, tb_blk;
  logic   tb_acc, tb_clear, tb_in_valid;

  logic   ov_all  [NDUT];
  logic   rdy_all [NDUT];
  gf128_t blk_all [NDUT];

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    ghash_mul_digit_if bus ();
    assign bus.H        = tb_h;
    assign bus.block_i  = tb_blk;
    assign bus.acc      = tb_acc;
    assign bus.clear    = tb_clear;
    assign bus.in_valid = tb_in_valid;
    assign ov_all[g]    = bus.out_valid;
    assign rdy_all[g]   = bus.in_ready;
    assign blk_all[g]   = bus.block_o;
    ghash_mul_digit #(.DIGIT(1 << g)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
    );
  end

  function automatic gf128_t gf_mul_ref(input gf128_t x, input gf128_t h);
    gf128_t z = '0;
    gf128_t v = x;
    for (int i = 0; i < 128; i++) begin
      if (h[127-i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ {8'hE1, 120'h0}) : (v >> 1);
    end
    return z;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input gf128_t h, input gf128_t blk, input logic acc,
                                input logic valid, input logic clr);
    tb_h        = h;
    tb_blk      = blk;
    tb_acc      = acc;
    tb_in_valid = valid;
    tb_clear    = clr;
  endtask

  task automatic check_output(input string tag, input gf128_t observed, input gf128_t expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic wait_out_valid(input int budget, output int cycles);
    cycles = -1;
    for (int c = 1; c <= budget; c++) begin
      tick();
      if (ov_all[M]) begin
        cycles = c;
        break;
      end
    end
  endtask

  initial begin
    int     cycles;
    int     pulses;
    int     lat [NDUT];
    int     nov [NDUT];
    gf128_t res [NDUT];
    gf128_t y_model, rh, rb;
    logic   racc;

    reset_n = 1'b0;
    apply_stimulus('0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check_output("reset_in_ready", gf128_t'(rdy_all[M]), gf128_t'(1));
    check_output("reset_out_valid", gf128_t'(ov_all[M]), '0);
    check_output("reset_block_o", blk_all[M], '0);
    reset_n = 1'b1;
    tick();
    check_output("release_in_ready", gf128_t'(rdy_all[M]), gf128_t'(1));

    // GCM vector on every DIGIT with latency and strobe width
    apply_stimulus(H1, X1, 1'b0, 1'b1, 1'b0);
    tick();
    apply_stimulus(H1, X1, 1'b0, 1'b0, 1'b0);
    check_output("busy_after_accept", gf128_t'(rdy_all[M]), '0);
    for (int d = 0; d < NDUT; d++) begin
      lat[d] = -1;
      nov[d] = 0;
      res[d] = '0;
    end
    for (int c = 1; c <= 140; c++) begin
      tick();
      for (int d = 0; d < NDUT; d++) begin
        if (ov_all[d]) begin
          nov[d]++;
          if (lat[d] < 0) begin
            lat[d] = c + 1;
            res[d] = blk_all[d];
          end
        end
      end
    end
    for (int d = 0; d < NDUT; d++) begin
      check_output($sformatf("latency_d%0d", 1 << d), gf128_t'(lat[d]), gf128_t'(128 / (1 << d) + 1));
      check_output($sformatf("result_d%0d", 1 << d), res[d], Y1);
      check_output($sformatf("strobes_d%0d", 1 << d), gf128_t'(nov[d]), gf128_t'(1));
      check_output($sformatf("held_d%0d", 1 << d), blk_all[d], Y1);
    end

    // GCM test case 2 tag hash: length block chained in the strobe cycle
    apply_stimulus(H1, X1, 1'b0, 1'b1, 1'b0);
    tick();
    apply_stimulus(H1, LEN, 1'b1, 1'b1, 1'b0);
    wait_out_valid(2 * N_M, cycles);
    check_output("chain_first_latency", gf128_t'(cycles), gf128_t'(N_M));
    check_output("chain_first_result", blk_all[M], Y1);
    check_output("chain_ready_on_strobe", gf128_t'(rdy_all[M]), gf128_t'(1));
    tick();
    apply_stimulus(H1, LEN, 1'b1, 1'b0, 1'b0);
    check_output("chain_accepted", gf128_t'(rdy_all[M]), '0);
    wait_out_valid(2 * N_M, cycles);
    check_output("chain_latency", gf128_t'(cycles), gf128_t'(N_M));
    check_output("chain_result", blk_all[M], Y2);

    apply_stimulus(ONE, XI, 1'b0, 1'b1, 1'b0);
    tick();
    apply_stimulus(ONE, XI, 1'b0, 1'b0, 1'b0);
    wait_out_valid(2 * N_M, cycles);
    check_output("identity_latency", gf128_t'(cycles), gf128_t'(N_M));
    check_output("identity_result", blk_all[M], XI);

    // clear while idle wins over a simultaneous in_valid
    apply_stimulus(H1, X1, 1'b0, 1'b1, 1'b1);
    tick();
    check_output("clear_idle_block_o", blk_all[M], '0);
    check_output("clear_idle_no_accept", gf128_t'(rdy_all[M]), gf128_t'(1));
    apply_stimulus(H1, X1, 1'b0, 1'b0, 1'b0);
    tick();
    check_output("clear_idle_no_strobe", gf128_t'(ov_all[M]), '0);

    apply_stimulus(ONE, XI, 1'b0, 1'b1, 1'b0);
    tick();
    apply_stimulus(ZERO_H(), XI, 1'b0, 1'b1, 1'b0);
    wait_out_valid(2 * N_M, cycles);
    check_output("identity2_result", blk_all[M], XI);
    tick();
    apply_stimulus('0, XI, 1'b0, 1'b0, 1'b0);
    wait_out_valid(2 * N_M, cycles);
    check_output("zero_h_latency", gf128_t'(cycles), gf128_t'(N_M));
    check_output("zero_h_result", blk_all[M], '0);

    // abort with clear in the third compute cycle
    apply_stimulus(H1, X1, 1'b0, 1'b1, 1'b0);
    tick();
    apply_stimulus(H1, X1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    apply_stimulus(H1, X1, 1'b0, 1'b0, 1'b1);
    tick();
    apply_stimulus(H1, X1, 1'b0, 1'b0, 1'b0);
    check_output("abort_in_ready", gf128_t'(rdy_all[M]), gf128_t'(1));
    check_output("abort_out_valid", gf128_t'(ov_all[M]), '0);
    check_output("abort_block_o", blk_all[M], '0);
    pulses = 0;
    for (int c = 1; c <= N_M + 4; c++) begin
      tick();
      if (ov_all[M]) pulses++;
    end
    check_output("abort_no_strobe", gf128_t'(pulses), '0);
    apply_stimulus(H1, X1, 1'b0, 1'b1, 1'b0);
    tick();
    apply_stimulus(H1, X1, 1'b0, 1'b0, 1'b0);
    wait_out_valid(2 * N_M, cycles);
    check_output("after_abort_latency", gf128_t'(cycles), gf128_t'(N_M));
    check_output("after_abort_result", blk_all[M], Y1);

    // asynchronous reset in the middle of a computation
    apply_stimulus(H1, X1, 1'b0, 1'b1, 1'b0);
    tick();
    apply_stimulus(H1, X1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check_output("async_reset_in_ready", gf128_t'(rdy_all[M]), gf128_t'(1));
    check_output("async_reset_out_valid", gf128_t'(ov_all[M]), '0);
    check_output("async_reset_block_o", blk_all[M], '0);
    tick();
    reset_n = 1'b1;
    pulses = 0;
    for (int c = 1; c <= N_M + 4; c++) begin
      tick();
      if (ov_all[M]) pulses++;
    end
    check_output("reset_no_strobe", gf128_t'(pulses), '0);

    // back-to-back random blocks with in_valid held high throughout
    y_model = '0;
    rh   = {$urandom, $urandom, $urandom, $urandom};
    rb   = {$urandom, $urandom, $urandom, $urandom};
    racc = 1'($urandom_range(0, 1));
    apply_stimulus(rh, rb, racc, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      y_model = gf_mul_ref(rb ^ (racc ? y_model : '0), rh);
      check_output($sformatf("rnd%0d_busy", i), gf128_t'(rdy_all[M]), '0);
      rh   = {$urandom, $urandom, $urandom, $urandom};
      rb   = {$urandom, $urandom, $urandom, $urandom};
      racc = 1'($urandom_range(0, 1));
      apply_stimulus(rh, rb, racc, (i < 9), 1'b0);
      wait_out_valid(2 * N_M, cycles);
      check_output($sformatf("rnd%0d_latency", i), gf128_t'(cycles), gf128_t'(N_M));
      check_output($sformatf("rnd%0d_result", i), blk_all[M], y_model);
      check_output($sformatf("rnd%0d_ready", i), gf128_t'(rdy_all[M]), gf128_t'(1));
    end

    $display("[TB] %0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  function automatic gf128_t ZERO_H();
    return '0;
  endfunction

endmodule
